// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM encoding and the
// chunk-index width helper.
package serial_adder_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Index register needs at least one bit even when there is a single chunk.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple adder; also reports the carry into its top
// bit so the caller can form signed overflow on the final chunk.
module adder_slice #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic carry;

   always_comb begin
      s        = '0;
      c_msb_in = 1'b0;
      carry    = ci;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) c_msb_in = carry;
         s[i]  = x[i] ^ y[i] ^ carry;
         carry = (x[i] & y[i]) | (x[i] & carry) | (y[i] & carry);
      end
      co = carry;
   end

endmodule

// File: rtl/serial_chunk_adder.sv
// Adds or subtracts two WIDTH-bit operands CHUNK bits per cycle, LSB chunk
// first; done pulses for one cycle once sum/carry/overflow are final.
module serial_chunk_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = idx_width(N);

   generate
      if ((CHUNK < 1) || (CHUNK > WIDTH) || (WIDTH % CHUNK != 0) ||
          (WIDTH < 2) || (WIDTH > 64)) begin : g_bad_params
         $error("serial_chunk_adder: illegal WIDTH/CHUNK combination");
      end
   endgenerate

   logic [1:0]       state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             c_q;
   logic [IW-1:0]    idx;

   logic [CHUNK-1:0] x_chunk;
   logic [CHUNK-1:0] y_chunk;
   logic [CHUNK-1:0] s_chunk;
   logic             co_chunk;
   logic             c_msb_chunk;
   logic             last_chunk;

   assign x_chunk    = a_q[int'(idx)*CHUNK +: CHUNK];
   assign y_chunk    = b_q[int'(idx)*CHUNK +: CHUNK];
   assign last_chunk = (idx == IW'(N - 1));

   adder_slice #(.CHUNK(CHUNK)) u_slice (
      .x        (x_chunk),
      .y        (y_chunk),
      .ci       (c_q),
      .s        (s_chunk),
      .co       (co_chunk),
      .c_msb_in (c_msb_chunk)
   );

   assign ready = (state == IDLE);
   assign done  = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtraction is a + ~b + 1, so invert b and force carry-in.
                  a_q   <= a;
                  b_q   <= sub ? ~b : b;
                  c_q   <= sub ? 1'b1 : cin;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum[int'(idx)*CHUNK +: CHUNK] <= s_chunk;
               c_q <= co_chunk;
               idx <= idx + 1'b1;
               if (last_chunk) begin
                  carry    <= co_chunk;
                  overflow <= c_msb_chunk ^ co_chunk;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed-vector bench for serial_chunk_adder at CHUNK=2 and CHUNK=8 (WIDTH=8).
module tb_serial_chunk_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       start8;
   logic [7:0] a;
   logic [7:0] b;
   logic       sub;
   logic       cin;

   logic       ready,  done,  carry,  overflow;
   logic [7:0] sum;
   logic       ready8, done8, carry8, overflow8;
   logic [7:0] sum8;

   int         n_vec = 0;
   int         n_bad = 0;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
      .ready(ready), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
   );

   serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .sub(sub), .cin(cin),
      .ready(ready8), .done(done8), .sum(sum8), .carry(carry8), .overflow(overflow8)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Entered and left at a negedge. poke > 0 pulses start with other operands
   // at that negedge count; tail is the number of idle negedges watched after done.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic ts, input logic tc, input logic [7:0] esum,
                         input logic ec, input logic ev, input int poke, input int tail);
      int         cnt;
      int         extra;
      logic [9:0] e;
      chk({tag, "_ready_pre"}, ready, 1'b1);
      exp_q.push_back({esum, ec, ev});
      a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
      @(posedge clk);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) begin
            start = 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
         end
         if (poke > 0 && cnt == poke) begin
            a = 8'hFF; b = 8'hFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
         end
         if (poke > 0 && cnt == poke + 1) start = 1'b0;
      end while (!done && cnt < 20);
      chk({tag, "_latency"}, cnt, 5);
      chk({tag, "_ready_done"}, ready, 1'b0);
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_sum"}, sum, e[9:2]);
         chk({tag, "_carry"}, carry, e[1]);
         chk({tag, "_ovf"}, overflow, e[0]);
      end
      extra = 0;
      for (int i = 0; i < tail; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) extra++;
      end
      if (tail > 0) begin
         chk({tag, "_extra_done"}, extra, 0);
         chk({tag, "_ready_post"}, ready, 1'b1);
         chk({tag, "_hold"}, {sum, carry, overflow}, {esum, ec, ev});
      end
   endtask

   task automatic run_op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic [7:0] esum, input logic ec,
                          input logic ev);
      int cnt;
      chk({tag, "_ready_pre"}, ready8, 1'b1);
      a = ta; b = tb; sub = 1'b0; cin = tc; start8 = 1'b1;
      @(posedge clk);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         start8 = 1'b0;
      end while (!done8 && cnt < 20);
      chk({tag, "_latency"}, cnt, 2);
      chk({tag, "_sum"}, sum8, esum);
      chk({tag, "_carry"}, carry8, ec);
      chk({tag, "_ovf"}, overflow8, ev);
      @(negedge clk);
      chk({tag, "_ready_post"}, ready8, 1'b1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start8 = 1'b0;
      a = 8'h00; b = 8'h00; sub = 1'b0; cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_outs", {sum, carry, overflow}, 10'h000);
      chk("rst_ready8", ready8, 1'b1);
      chk("rst_outs8", {sum8, carry8, overflow8}, 10'h000);
      rst = 1'b0;

      // First op issued straight out of reset, then back-to-back.
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1);
      run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1);
      run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 0, 1);
      run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 0, 2);
      run_op("add_3c_4a_c", 8'h3C, 8'h4A, 1'b0, 1'b1, 8'h87, 1'b0, 1'b1, 0, 1);
      run_op("sub_00_00", 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1);
      run_op("add_aa_55_c", 8'hAA, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1);
      run_op("poke_run", 8'h12, 8'h21, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 2, 8);
      run_op("poke_done", 8'h40, 8'h41, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 5, 8);

      // Abort in the middle of RUN (chunk 2 in flight).
      a = 8'h55; b = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_done", done, 1'b0);
      chk("abort_ready", ready, 1'b1);
      chk("abort_outs", {sum, carry, overflow}, 10'h000);
      run_op("after_abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 0, 2);

      run_op8("c8_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
      run_op8("c8_f0_20_c", 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0);
      run_op8("c8_40_40", 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
